usb_rx_unstuff: RTL

USB_RX_UNSTUFF -- requirements
Module: usb_rx_unstuff

---
 rtl/usb_rx_pkg.sv | 21 ++
 rtl/usb_bit_unstuff.sv | 48 ++++
 rtl/usb_rx_unstuff.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/usb_rx_pkg.sv
// Shared types and defaults for the USB receive NRZI decoder and bit unstuffer.
package usb_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERROR  = 2'd2
  } rx_state_e;

  localparam logic LINE_J = 1'b1;
  localparam logic LINE_K = 1'b0;

  localparam int unsigned SYNC_MIN_ZEROS_DEF = 5;
  localparam int unsigned STUFF_LEN_DEF      = 6;

  localparam int unsigned ZERO_CNT_W   = 4;
  localparam int unsigned ZERO_CNT_MAX = 15;
  localparam int unsigned BIT_CNT_W    = 3;
  localparam int unsigned BYTE_W       = 8;

endpackage

// File: rtl/usb_bit_unstuff.sv
// Ones-run tracker: drops the stuffed 0 after STUFF_LEN decoded 1s and flags a stuffed 1.
module usb_bit_unstuff
  import usb_rx_pkg::*;
#(
  parameter int unsigned STUFF_LEN = STUFF_LEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic dec_i,
  input  logic valid_i,
  output logic out_bit_c,
  output logic out_valid_c,
  output logic stuff_err_c
);

  localparam int unsigned ONES_W = $clog2(STUFF_LEN + 1);

  logic [ONES_W-1:0] ones_q, ones_d;
  logic              stuff_slot_c;

  assign stuff_slot_c = (ones_q == ONES_W'(STUFF_LEN));

  // The closing SYNC 1 seeds the run, so a load starts it at 1.
  always_comb begin
    ones_d      = ones_q;
    out_bit_c   = dec_i;
    out_valid_c = 1'b0;
    stuff_err_c = 1'b0;
    if (load_i) begin
      ones_d = ONES_W'(1);
    end else if (valid_i) begin
      if (stuff_slot_c) begin
        if (dec_i) stuff_err_c = 1'b1;
        else       ones_d      = '0;
      end else begin
        out_valid_c = 1'b1;
        ones_d      = dec_i ? ones_q + ONES_W'(1) : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ones_q <= '0;
    else        ones_q <= ones_d;
  end

endmodule

// File: rtl/usb_rx_unstuff.sv
// USB receive front end: NRZI decode, SYNC hunt, unstuff, byte assembly, EOP/error strobes.
// Optional RX_ERR_COUNT_EN adds a saturating ErrCount output.
module usb_rx_unstuff
  import usb_rx_pkg::*;
#(
  parameter int unsigned SYNC_MIN_ZEROS = SYNC_MIN_ZEROS_DEF,
  parameter int unsigned STUFF_LEN      = STUFF_LEN_DEF
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Data,
  input  logic        DataValid,
  input  logic        Se0,
  input  logic        Underflow,
  input  logic        Overflow,
`ifdef RX_ERR_COUNT_EN
  output logic [7:0]  ErrCount,
`endif
  output logic [7:0]  RxByte,
  output logic        RxByteValid,
  output logic        RxActive,
  output logic        EopDetect,
  output logic        RxError
);

  rx_state_e               state_q, state_d;
  logic                    prev_q, prev_d;
  logic                    fault_q;
  logic [ZERO_CNT_W-1:0]   zero_q, zero_d;
  logic [BIT_CNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic [BYTE_W-1:0]       sr_q, sr_d, byte_q, byte_d;
  logic                    bv_q, bv_d, eop_q, eop_d, err_q, err_d, act_q;

  logic dec_c, bit_ok_c, fault_rise_c, sync_hit_c, us_valid_c;
  logic us_bit_c, us_out_valid_c, us_err_c;

  assign dec_c        = (Data == prev_q);
  assign bit_ok_c     = DataValid & ~Se0;
  assign fault_rise_c = (Underflow | Overflow) & ~fault_q;
  assign sync_hit_c   = bit_ok_c & dec_c & ~fault_rise_c & (state_q == IDLE) &
                        (32'(zero_q) >= SYNC_MIN_ZEROS);
  assign us_valid_c   = bit_ok_c & ~fault_rise_c & (state_q == ACTIVE);

  usb_bit_unstuff #(.STUFF_LEN(STUFF_LEN)) u_unstuff (
    .clk         (Clock),
    .rst_n       (Reset_n),
    .load_i      (sync_hit_c),
    .dec_i       (dec_c),
    .valid_i     (us_valid_c),
    .out_bit_c   (us_bit_c),
    .out_valid_c (us_out_valid_c),
    .stuff_err_c (us_err_c)
  );

  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    zero_d   = zero_q;
    bitcnt_d = bitcnt_q;
    sr_d     = sr_q;
    byte_d   = byte_q;
    bv_d     = 1'b0;
    eop_d    = 1'b0;
    err_d    = 1'b0;

    if (DataValid) prev_d = Se0 ? LINE_J : Data;

    // FIFO faults pre-empt any data or SE0 arriving in the same cycle.
    if (fault_rise_c) begin
      err_d    = 1'b1;
      state_d  = ERROR;
      zero_d   = '0;
      bitcnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (DataValid) begin
            if (Se0) begin
              zero_d = '0;
            end else if (!dec_c) begin
              if (zero_q != ZERO_CNT_W'(ZERO_CNT_MAX)) zero_d = zero_q + ZERO_CNT_W'(1);
            end else begin
              zero_d   = '0;
              bitcnt_d = '0;
              if (sync_hit_c) state_d = ACTIVE;
            end
          end
        end
        ACTIVE: begin
          if (DataValid && Se0) begin
            state_d  = IDLE;
            bitcnt_d = '0;
            if (bitcnt_q == '0) eop_d = 1'b1;
            else                err_d = 1'b1;
          end else if (us_err_c) begin
            err_d    = 1'b1;
            state_d  = ERROR;
            bitcnt_d = '0;
          end else if (us_out_valid_c) begin
            sr_d     = {us_bit_c, sr_q[BYTE_W-1:1]};
            bitcnt_d = bitcnt_q + BIT_CNT_W'(1);
            if (bitcnt_q == BIT_CNT_W'(BYTE_W - 1)) begin
              byte_d = sr_d;
              bv_d   = 1'b1;
            end
          end
        end
        ERROR: begin
          if (DataValid && Se0) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      prev_q   <= LINE_J;
      fault_q  <= 1'b0;
      zero_q   <= '0;
      bitcnt_q <= '0;
      sr_q     <= '0;
      byte_q   <= '0;
      bv_q     <= 1'b0;
      eop_q    <= 1'b0;
      err_q    <= 1'b0;
      act_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      fault_q  <= Underflow | Overflow;
      zero_q   <= zero_d;
      bitcnt_q <= bitcnt_d;
      sr_q     <= sr_d;
      byte_q   <= byte_d;
      bv_q     <= bv_d;
      eop_q    <= eop_d;
      err_q    <= err_d;
      act_q    <= (state_d == ACTIVE);
    end
  end

  assign RxByte      = byte_q;
  assign RxByteValid = bv_q;
  assign EopDetect   = eop_q;
  assign RxError     = err_q;
  assign RxActive    = act_q;

`ifdef RX_ERR_COUNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)                         err_cnt_q <= 8'h00;
    else if (err_d && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
  end

  assign ErrCount = err_cnt_q;
`endif

endmodule
